// File: rtl/ccm_ctr_unpack.sv
// ccm_ctr_unpack
//   Sits after the CCM counter-mode XOR stage. Each block arrives as a burst of
//   BLOCK_BYTES bytes, one per cycle, with no backpressure. Bytes beyond the
//   message length are padding and are thrown away. Payload bytes are queued
//   in a FIFO and handed to the consumer on a valid/ready byte stream. The
//   stream marks the final byte with out_last. msg_done pulses once the message
//   has been fully delivered.
//
// Optional feature:
//   CCM_UNPACK_OVF_EN  when defined, a write attempted into a full FIFO with no
//                      read in the same cycle sets the sticky overflow flag.
//                      When undefined, such a byte is dropped silently and
//                      overflow is tied to 0.
//
// Ports:
//   clk         clock
//   reset       synchronous, active-high reset
//   msg_start   pulse in IDLE: start a message and latch msg_length
//   msg_length  message length in bytes (0 .. 2^WIDTH-1)
//   in_data     byte from the counter stage (LSB byte of the block first)
//   in_en       in_data valid; BLOCK_BYTES consecutive cycles per block
//   space_ok    FIFO has room for at least one more full block
//   out_data    payload byte (0 when out_valid is low)
//   out_valid   out_data valid
//   out_ready   consumer accepts the byte when out_valid & out_ready
//   out_last    with out_valid: final payload byte of the message
//   msg_done    one-cycle pulse when the message completes
//   busy        a message is in progress (state != IDLE)
//   overflow    sticky FIFO overflow error (see CCM_UNPACK_OVF_EN)
module ccm_ctr_unpack #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 32,
  parameter int BLOCK_BYTES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             msg_start,
  input  logic [WIDTH-1:0] msg_length,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_en,
  output logic             space_ok,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             msg_done,
  output logic             busy,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int BW = $clog2(BLOCK_BYTES);

  localparam logic [CW-1:0]    FULL_COUNT  = CW'(DEPTH);
  localparam logic [CW-1:0]    BLOCK_COUNT = CW'(BLOCK_BYTES);
  localparam logic [BW-1:0]    BLK_LAST    = BW'(BLOCK_BYTES - 1);
  localparam logic [WIDTH-1:0] ONE_BYTE    = WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t state_reg;
  state_t state_next;

  logic [WIDTH-1:0] remaining_reg;
  logic [BW-1:0]    blk_cnt_reg;
  logic             last_seen_reg;

  // FIFO storage: {last flag, data byte}
  logic [WIDTH:0]   mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;

  logic             in_take;
  logic             wr_req;
  logic             wr_fire;
  logic             rd_fire;
  logic             fifo_full;
  logic             blk_wrap;
  logic             last_acc;
  logic             wr_last;
  logic [WIDTH-1:0] remaining_after;
  logic [WIDTH:0]   head_word;

  // ---------------------------------------------------------------------------
  // Datapath decode
  // ---------------------------------------------------------------------------
  // Input bytes only count while receiving. Bytes that arrive in any other
  // state are ignored entirely.
  assign in_take   = (state_reg == ST_RECV) && in_en;
  // Payload byte: still inside the message length. Anything else is padding.
  assign wr_req    = in_take && (remaining_reg != '0);
  assign fifo_full = (count_reg == FULL_COUNT);
  assign rd_fire   = out_valid && out_ready;
  // A read in the same cycle frees an entry, so a full FIFO can still take
  // the write.
  assign wr_fire   = wr_req && (!fifo_full || rd_fire);
  assign wr_last   = (remaining_reg == ONE_BYTE);
  assign blk_wrap  = in_take && (blk_cnt_reg == BLK_LAST);
  assign last_acc  = rd_fire && out_last;

  // remaining decrements on every payload byte, even one dropped because the
  // FIFO was full, so the message framing stays aligned with the bursts.
  assign remaining_after = wr_req ? (remaining_reg - ONE_BYTE) : remaining_reg;

  // ---------------------------------------------------------------------------
  // FIFO output: the head entry is read combinationally, so a byte written at
  // one edge is presented during the very next cycle.
  // ---------------------------------------------------------------------------
  assign head_word = mem[rd_ptr_reg];
  assign out_valid = (count_reg != '0);
  assign out_data  = out_valid ? head_word[WIDTH-1:0] : '0;
  assign out_last  = out_valid && head_word[WIDTH];
  assign space_ok  = ((FULL_COUNT - count_reg) >= BLOCK_COUNT);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    busy       = (state_reg != ST_IDLE);
    msg_done   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (msg_start) begin
          state_next = (msg_length == '0) ? ST_DONE : ST_RECV;
        end
      end
      ST_RECV: begin
        // Stay until the payload is complete and the current burst has ended.
        // Short messages can have their last byte consumed while padding is
        // still arriving. In that case no drain phase is needed.
        if (blk_wrap && (remaining_after == '0)) begin
          state_next = (last_seen_reg || last_acc) ? ST_DONE : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (last_acc) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        msg_done   = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Message counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      remaining_reg <= '0;
      blk_cnt_reg   <= '0;
      last_seen_reg <= 1'b0;
    end else if ((state_reg == ST_IDLE) && msg_start) begin
      remaining_reg <= msg_length;
      blk_cnt_reg   <= '0;
      last_seen_reg <= 1'b0;
    end else begin
      remaining_reg <= remaining_after;
      if (in_take) begin
        blk_cnt_reg <= blk_wrap ? '0 : (blk_cnt_reg + BW'(1));
      end
      if (last_acc) begin
        last_seen_reg <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO pointers and occupancy
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_fire) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (rd_fire) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({wr_fire, rd_fire})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage has no reset. Only occupied entries are ever presented.
  // A write into a full FIFO (allowed only alongside a read) targets the
  // slot being read this cycle, and the head has already been consumed.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_ptr_reg] <= {wr_last, in_data};
    end
  end

  // ---------------------------------------------------------------------------
  // Overflow reporting
  // ---------------------------------------------------------------------------
`ifdef CCM_UNPACK_OVF_EN
  logic overflow_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_reg <= 1'b0;
    end else if (wr_req && fifo_full && !rd_fire) begin
      overflow_reg <= 1'b1;
    end
  end

  assign overflow = overflow_reg;
`else
  assign overflow = 1'b0;
`endif

endmodule
